// File: rtl/vga_framebuffer_fetch.sv
// Framebuffer fetch controller: issues credit-limited burst reads for each frame
// and forwards returning read beats into the downstream pixel FIFO.
module vga_framebuffer_fetch #(
    parameter int FIFO_DEPTH      = 1024,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FRAME_WORDS     = 153600
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        frame_start_i,
    input  logic [31:0] frame_base_i,
    input  logic        fifo_pop_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    output logic [7:0]  rd_len_o,
    input  logic        rd_accept_i,
    input  logic        rd_resp_valid_i,
    input  logic [31:0] rd_resp_data_i,
    input  logic        rd_resp_last_i,
    output logic [31:0] fifo_data_o,
    output logic        fifo_push_o,
    input  logic        fifo_accept_i,
    output logic        busy_o,
    output logic        frame_err_o,
    output logic        ovf_err_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WAIT, FETCH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q;
    logic [23:0]   remain_q;
    logic [CW-1:0] credit_q;
    logic [3:0]    outst_q;
    logic          hold_q;
    logic          push_q;
    logic [31:0]   data_q;
    logic          frame_err_q;
    logic          ovf_err_q;

    logic [8:0]    len;
    logic          can_issue;
    logic          accept;
    logic          resp_ok;
    logic          resp_done;
    logic [CW:0]   csum;
    logic          credit_ovf;

    always_comb begin
        len = (remain_q >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : remain_q[8:0];
    end

    assign can_issue = (state_q == FETCH) && (remain_q != '0) &&
                       (32'(credit_q) >= 32'(len)) &&
                       (outst_q < 4'(MAX_OUTSTANDING));

    // A raised request is held until accepted, even after leaving FETCH.
    assign rd_req_o  = hold_q | can_issue;
    assign accept    = rd_req_o & rd_accept_i;
    assign rd_addr_o = rd_req_o ? addr_q : '0;
    assign rd_len_o  = rd_req_o ? 8'(len - 9'd1) : '0;

    // Beats arriving with nothing outstanding (e.g. left over from before a reset) are dropped.
    assign resp_ok   = rd_resp_valid_i && (outst_q != '0);
    assign resp_done = resp_ok && rd_resp_last_i;

    always_comb begin
        csum = (CW+1)'(credit_q) + (CW+1)'(fifo_pop_i);
        if (accept) csum = csum - (CW+1)'(len);
    end
    assign credit_ovf = (csum > CREDIT_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable_i) state_d = WAIT;
            WAIT: begin
                if (!enable_i)          state_d = IDLE;
                else if (frame_start_i) state_d = FETCH;
            end
            FETCH: if (remain_q == '0 || !enable_i) state_d = DRAIN;
            DRAIN: if (outst_q == '0 && !hold_q) state_d = enable_i ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remain_q    <= '0;
            credit_q    <= CREDIT_MAX[CW-1:0];
            outst_q     <= '0;
            hold_q      <= 1'b0;
            push_q      <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            hold_q <= rd_req_o & ~rd_accept_i;
            if (state_q == WAIT && state_d == FETCH) begin
                addr_q   <= frame_base_i;
                remain_q <= 24'(FRAME_WORDS);
            end else if (accept) begin
                addr_q   <= addr_q + 32'({len, 2'b00});
                remain_q <= remain_q - 24'(len);
            end
            credit_q <= credit_ovf ? CREDIT_MAX[CW-1:0] : csum[CW-1:0];
            case ({accept, resp_done})
                2'b10:   outst_q <= outst_q + 4'd1;
                2'b01:   outst_q <= outst_q - 4'd1;
                default: outst_q <= outst_q;
            endcase
            push_q <= resp_ok;
            data_q <= rd_resp_data_i;
            if (frame_start_i && (state_q == FETCH || state_q == DRAIN)) frame_err_q <= 1'b1;
            // Pushing into a full FIFO or popping more than was ever pushed.
            if ((push_q && !fifo_accept_i) || credit_ovf) ovf_err_q <= 1'b1;
        end
    end

    assign fifo_push_o = push_q;
    assign fifo_data_o = data_q;
    assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
    assign frame_err_o = frame_err_q;
    assign ovf_err_o   = ovf_err_q;

endmodule
